// File: rtl/nibble_sort_sequencer.sv
// Bubble-sorts a DEPTH-element burst through one shared comparator: load, sort in place, drain.
// Build option SORT_EARLY_EXIT_EN ends the sort after the first pass with no swaps.
module nibble_sort_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       swap_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_CMP  = PW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    idx_nxt;
  logic [PW-1:0]    pass;
  logic             swapped;
  logic             gt;
  logic             early_exit;
  logic             do_load;
  logic             do_swap;

  // The single magnitude comparator; only "greater" triggers a swap, so equal keys stay stable.
  assign idx_nxt = idx + 1'b1;
  assign gt      = mem[idx] > mem[idx_nxt];

`ifdef SORT_EARLY_EXIT_EN
  assign early_exit = !(swapped || gt);
`else
  assign early_exit = 1'b0;
`endif

  assign do_load = (state == LOAD) && in_valid;
  assign do_swap = (state == SORT) && gt;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == SORT);
  assign out_last  = (state == DRAIN) && (rd_ptr == LAST_IDX);
  assign out_data  = (state == DRAIN) ? mem[rd_ptr] : '0;

  // Storage carries no reset: a discarded burst is simply overwritten by the next load.
  always_ff @(posedge clk) begin
    if (do_load) begin
      mem[wr_ptr] <= in_data;
    end else if (do_swap) begin
      mem[idx]     <= mem[idx_nxt];
      mem[idx_nxt] <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
      swap_cnt <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_ptr == LAST_IDX) begin
              wr_ptr   <= '0;
              idx      <= '0;
              pass     <= '0;
              swapped  <= 1'b0;
              swap_cnt <= 8'd0;
              state    <= SORT;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        SORT: begin
          if (gt && (swap_cnt != 8'hFF)) begin
            swap_cnt <= swap_cnt + 8'd1;
          end
          if (idx == LAST_CMP) begin
            idx     <= '0;
            pass    <= pass + 1'b1;
            swapped <= 1'b0;
            if ((pass == LAST_PASS) || early_exit) begin
              rd_ptr <= '0;
              state  <= DRAIN;
            end
          end else begin
            idx     <= idx_nxt;
            swapped <= swapped | gt;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == LAST_IDX) begin
              rd_ptr <= '0;
              wr_ptr <= '0;
              state  <= LOAD;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
